// File: rtl/addsub_cmd_sequencer.sv
// addsub_cmd_sequencer: FIFO-buffered command driver for an external combinational add/sub, with a valid/ready result port.
// Define ADDSUB_OPCOUNT_EN to add the op_count result-handshake counter.
module addsub_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_sub,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cntr,
  input  logic             add_cy,
  input  logic [WIDTH-1:0] add_f,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_f,
  output logic             res_cy,
`ifdef ADDSUB_OPCOUNT_EN
  output logic [7:0]       op_count,
`endif
  output logic             res_sub
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;
  state_t state;
  logic [2*WIDTH:0] mem [FIFO_DEPTH];
  logic [2*WIDTH:0] head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic empty, full, push, pop, res_hs;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full;
  assign push = cmd_valid && !full;
  assign res_hs = res_valid && res_ready;
  assign pop = !empty && (state == IDLE || (state == HOLD && res_hs));
  assign head = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_sub, cmd_a, cmd_b};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  // Adder inputs only move on a pop, so they stay stable through DRIVE and HOLD.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      add_a <= '0;
      add_b <= '0;
      add_cntr <= 1'b0;
      res_valid <= 1'b0;
      res_f <= '0;
      res_cy <= 1'b0;
      res_sub <= 1'b0;
    end else begin
      if (pop) {add_cntr, add_a, add_b} <= head;
      case (state)
        IDLE: if (!empty) state <= DRIVE;
        DRIVE: begin
          res_f <= add_f;
          res_cy <= add_cy;
          res_sub <= add_cntr;
          res_valid <= 1'b1;
          state <= HOLD;
        end
        HOLD: if (res_ready) begin
          res_valid <= 1'b0;
          state <= empty ? IDLE : DRIVE;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef ADDSUB_OPCOUNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) op_count <= 8'd0;
    else if (res_hs) op_count <= op_count + 8'd1;
`endif
endmodule

// File: tb/tb_addsub_cmd_sequencer.sv
// tb_addsub_cmd_sequencer: scoreboard bench with a behavioural adder/subtractor attached to the sequencer.
module tb_addsub_cmd_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, cmd_sub = 1'b0, res_ready = 1'b1;
  logic [3:0] cmd_a = '0, cmd_b = '0;
  logic cmd_ready, add_cntr, add_cy, res_valid, res_cy, res_sub;
  logic [3:0] add_a, add_b, add_f, res_f;
`ifdef ADDSUB_OPCOUNT_EN
  logic [7:0] op_count;
`endif
  int n_chk = 0, n_pass = 0, cyc = 0, hs_prev = 0, hs_last = 0;
  logic [5:0] exp_q[$];

  addsub_cmd_sequencer #(.WIDTH(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sub(cmd_sub),
    .add_a(add_a), .add_b(add_b), .add_cntr(add_cntr), .add_cy(add_cy), .add_f(add_f),
    .res_valid(res_valid), .res_ready(res_ready), .res_f(res_f), .res_cy(res_cy),
`ifdef ADDSUB_OPCOUNT_EN
    .op_count(op_count),
`endif
    .res_sub(res_sub)
  );

  // adder: add gives sum/carry; sub gives |a-b| with cy flagging a<b
  logic [4:0] sum;
  assign sum = {1'b0, add_a} + {1'b0, add_b};
  assign add_cy = add_cntr ? (add_a < add_b) : sum[4];
  assign add_f = add_cntr ? ((add_a < add_b) ? add_b - add_a : add_a - add_b) : sum[3:0];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk)
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_result: got %0h with no result pending", {res_sub, res_cy, res_f});
      end else chk("result", {res_sub, res_cy, res_f}, exp_q.pop_front());
      hs_prev = hs_last;
      hs_last = cyc;
    end

  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic s, input logic [5:0] e, input bit keep);
    int n = 0;
    cmd_a = a; cmd_b = b; cmd_sub = s; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready) begin
      n_chk++;
      $display("FAIL push_timeout: cmd_ready %0b required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (keep) exp_q.push_back(e);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk); n++;
    end
    #1 chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1;
    chk("reset_outs", {res_valid, res_f, res_cy, res_sub, add_a, add_b, add_cntr}, 0);
    chk("reset_ready", cmd_ready, 1);
`ifdef ADDSUB_OPCOUNT_EN
    chk("reset_opcount", op_count, 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // 1: latency and plain add
    push(4'b1010, 4'b0101, 1'b0, 6'b0_0_1111, 1);
    chk("t1_lat0", res_valid, 0);
    @(posedge clk); #1 chk("t1_lat1", res_valid, 0);
    @(posedge clk); #1 chk("t1_lat2", res_valid, 1);
    drain();
    // 2: subtract both signs
    push(4'b1010, 4'b0101, 1'b1, 6'b1_0_0101, 1);
    push(4'b0101, 4'b1010, 1'b1, 6'b1_1_0101, 1);
    drain();
    // 3: back-to-back spacing
    push(4'b0011, 4'b0100, 1'b0, 6'b0_0_0111, 1);
    push(4'b1111, 4'b1010, 1'b1, 6'b1_0_0101, 1);
    drain();
    chk("t3_spacing", hs_last - hs_prev, 2);
    // 4: stall, fill FIFO, release
    res_ready = 1'b0;
    push(4'b0001, 4'b0001, 1'b0, 6'b0_0_0010, 1);
    push(4'b1000, 4'b1000, 1'b0, 6'b0_1_0000, 1);
    push(4'b0111, 4'b0011, 1'b1, 6'b1_0_0100, 1);
    push(4'b0010, 4'b0110, 1'b1, 6'b1_1_0100, 1);
    chk("t4_ready_before_full", cmd_ready, 1);
    push(4'b1111, 4'b0001, 1'b0, 6'b0_1_0000, 1);
    chk("t4_ready_full", cmd_ready, 0);
    chk("t4_held", {res_valid, res_sub, res_cy, res_f}, 7'b1_0_0_0010);
    repeat (5) @(posedge clk);
    #1 chk("t4_stable", {res_valid, res_sub, res_cy, res_f}, 7'b1_0_0_0010);
    chk("t4_still_full", cmd_ready, 0);
    res_ready = 1'b1;
    drain();
    chk("t4_ready_after", cmd_ready, 1);
    // 5: reset during DRIVE with two queued; only the first result survives
    push(4'b0001, 4'b0010, 1'b0, 6'b0_0_0011, 1);
    push(4'b0100, 4'b0100, 1'b0, 6'b0_0_1000, 0);
    push(4'b0110, 4'b0001, 1'b1, 6'b1_0_0101, 0);
    push(4'b0011, 4'b0011, 1'b0, 6'b0_0_0110, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_outs_zero", {res_valid, res_f, res_cy, res_sub, add_a, add_b, add_cntr}, 0);
    chk("t5_ready", cmd_ready, 1);
`ifdef ADDSUB_OPCOUNT_EN
    chk("t5_opcount", op_count, 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1 chk("t5_no_result", res_valid, 0);
    chk("t5_queue", exp_q.size(), 0);
`ifdef ADDSUB_OPCOUNT_EN
    // 6: op_count wrap after 257 results
    for (int i = 0; i < 257; i++) push(4'b0000, 4'b0000, 1'b0, 6'b0_0_0000, 1);
    drain();
    chk("t6_opcount", op_count, 1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
